// File: rtl/keyed_echo_pkg.sv
//==============================================================================
// Module   : keyed_echo_pkg
// Desc     : Shared types and elaboration-time helpers for keyed_echo_gate.
//            Holds the gate state encoding and the KMP failure-table builder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package keyed_echo_pkg;

    // Largest key the failure-table builder can handle.
    localparam int c_MAX_KEY_LEN = 64;

    typedef enum logic [1:0] {
        ST_ECHO   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SEND   = 2'd3
    } gate_state_t;

    // Entry i is the length of the longest proper prefix of key[0..i]
    // that is also a suffix of it.
    typedef logic [c_MAX_KEY_LEN-1:0][7:0] fail_tab_t;

    function automatic fail_tab_t kmp_fail(
        input logic [8*c_MAX_KEY_LEN-1:0] key,
        input int                         key_len
    );
        fail_tab_t tab;
        int        k;
        tab = '0;
        k   = 0;
        for (int i = 1; i < c_MAX_KEY_LEN; i++) begin
            if (i < key_len) begin
                while ((k > 0) && (key[8*i +: 8] != key[8*k +: 8])) begin
                    k = int'(tab[k-1]);
                end
                if (key[8*i +: 8] == key[8*k +: 8]) begin
                    k = k + 1;
                end
                tab[i] = 8'(k);
            end
        end
        return tab;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
//==============================================================================
// Module   : byte_fifo
// Desc     : Small registered byte FIFO without bypass. A push into a full
//            FIFO is accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module byte_fifo #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_PW-1:0] r_rd;
    logic [c_PW-1:0] r_wr;
    logic [c_CW-1:0] r_cnt;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty     = (r_cnt == '0);
    assign full      = (int'(r_cnt) == DEPTH);
    assign head      = r_mem[r_rd];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Data storage; contents are only meaningful under the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= (int'(r_wr) == DEPTH - 1) ? '0 : r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= (int'(r_rd) == DEPTH - 1) ? '0 : r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/keyed_echo_gate.sv
//==============================================================================
// Module   : keyed_echo_gate
// Desc     : Byte echo gate with a KMP key matcher. Echoes input through a
//            2-entry FIFO; on key match drains and sends a fixed message.
//            Repeated failed attempts trigger a timed lockout.
//            KEY_LEN is limited to keyed_echo_pkg::c_MAX_KEY_LEN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module keyed_echo_gate
    import keyed_echo_pkg::*;
#(
    parameter int                   KEY_LEN        = 20,
    parameter logic [8*KEY_LEN-1:0] KEY            = '0,
    parameter int                   MSG_LEN        = 40,
    parameter logic [8*MSG_LEN-1:0] MSG            = '0,
    parameter int                   MAX_FAILS      = 0,
    parameter int                   LOCKOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       unlocked,
    output logic       locked,
    output logic       overflow
);

    localparam int c_MW = $clog2(KEY_LEN + 1);
    localparam int c_FW = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1;
    localparam int c_TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int c_IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    localparam logic [8*c_MAX_KEY_LEN-1:0] c_KEY_PAD = (8*c_MAX_KEY_LEN)'(KEY);
    localparam fail_tab_t                  c_FAIL    = kmp_fail(c_KEY_PAD, KEY_LEN);

    gate_state_t     r_state, w_state_nxt;
    logic [c_MW-1:0] r_m, w_m_nxt;
    logic [c_FW-1:0] r_fail_cnt, w_fail_nxt;
    logic [c_TW-1:0] r_timer, w_timer_nxt;
    logic [c_IW-1:0] r_idx, w_idx_nxt;
    logic            r_overflow;

    logic            w_push, w_pop, w_full, w_empty, w_ovf_set;
    logic [7:0]      w_head;
    int              w_k;
    logic            w_complete, w_failed;

    logic [7:0]      w_key  [KEY_LEN];
    int              w_fail [KEY_LEN];
    logic [7:0]      w_msg  [MSG_LEN];

    for (genvar g = 0; g < KEY_LEN; g++) begin : g_key
        assign w_key[g]  = KEY[8*g +: 8];
        assign w_fail[g] = int'(c_FAIL[g]);
    end

    for (genvar g = 0; g < MSG_LEN; g++) begin : g_msg
        assign w_msg[g] = MSG[8*g +: 8];
    end

    byte_fifo #(
        .DEPTH (2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_byte),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // KMP step: follow failure links until the byte extends a prefix or m hits 0.
    always_comb begin
        int   k;
        logic done;
        k    = int'(r_m);
        done = 1'b0;
        for (int it = 0; it <= KEY_LEN; it++) begin
            if (!done) begin
                if (w_key[k] == in_byte) begin
                    k    = k + 1;
                    done = 1'b1;
                end else if (k == 0) begin
                    done = 1'b1;
                end else begin
                    k = w_fail[k-1];
                end
            end
        end
        w_k = k;
    end

    assign w_complete = (w_k == KEY_LEN);
    assign w_failed   = (r_m != '0) && (w_k <= int'(r_m));

    // Next-state, FIFO control and output selection.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_fail_nxt  = r_fail_cnt;
        w_timer_nxt = r_timer;
        w_idx_nxt   = r_idx;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_set   = 1'b0;
        out_valid   = 1'b0;
        out_byte    = 8'h00;

        if (r_state != ST_SEND) begin
            out_valid = !w_empty;
            out_byte  = w_empty ? 8'h00 : w_head;
            w_pop     = !w_empty && out_ready;
        end

        // Echo path; DRAIN and SEND discard input entirely.
        if (in_valid && ((r_state == ST_ECHO) || (r_state == ST_LOCKED))) begin
            if (!w_full || w_pop) begin
                w_push = 1'b1;
            end else begin
                w_ovf_set = 1'b1;
            end
        end

        case (r_state)
            ST_ECHO: begin
                if (in_valid) begin
                    if (w_complete) begin
                        w_state_nxt = ST_DRAIN;
                        w_m_nxt     = '0;
                        w_fail_nxt  = '0;
                    end else begin
                        w_m_nxt = c_MW'(w_k);
                        if ((MAX_FAILS > 0) && w_failed) begin
                            w_fail_nxt = r_fail_cnt + 1'b1;
                            if (int'(r_fail_cnt) + 1 >= MAX_FAILS) begin
                                w_state_nxt = ST_LOCKED;
                                w_m_nxt     = '0;
                                w_timer_nxt = '0;
                            end
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (int'(r_timer) == LOCKOUT_CYCLES - 1) begin
                    w_state_nxt = ST_ECHO;
                    w_timer_nxt = '0;
                    w_fail_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_SEND;
                    w_idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_byte  = w_msg[r_idx];
                if (out_ready) begin
                    if (int'(r_idx) == MSG_LEN - 1) begin
                        w_state_nxt = ST_ECHO;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ECHO;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ECHO;
            r_m        <= '0;
            r_fail_cnt <= '0;
            r_timer    <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_m        <= w_m_nxt;
            r_fail_cnt <= w_fail_nxt;
            r_timer    <= w_timer_nxt;
            r_idx      <= w_idx_nxt;
            r_overflow <= r_overflow | w_ovf_set;
        end
    end

    assign unlocked = (r_state == ST_DRAIN) || (r_state == ST_SEND);
    assign locked   = (r_state == ST_LOCKED);
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_keyed_echo_gate.sv
//==============================================================================
// Module   : tb_keyed_echo_gate
// Desc     : Scoreboard bench for keyed_echo_gate with key "aab", message "OK",
//            two failures allowed and an 8-cycle lockout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_keyed_echo_gate;

    localparam int          c_KEY_LEN = 3;
    localparam logic [23:0] c_KEY     = 24'h626161;   // 'a','a','b' from byte 0
    localparam int          c_MSG_LEN = 2;
    localparam logic [15:0] c_MSG     = 16'h4B4F;     // 'O','K'
    localparam logic [7:0]  c_A = 8'h61, c_B = 8'h62, c_X = 8'h78;
    localparam logic [7:0]  c_O = 8'h4F, c_K = 8'h4B;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       unlocked;
    logic       locked;
    logic       overflow;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] r_exp;
    logic       r_found;
    int         n_locked;

    keyed_echo_gate #(
        .KEY_LEN        (c_KEY_LEN),
        .KEY            (c_KEY),
        .MSG_LEN        (c_MSG_LEN),
        .MSG            (c_MSG),
        .MAX_FAILS      (2),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .unlocked  (unlocked),
        .locked    (locked),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One input strobe; optionally record the byte as an expected echo.
    task automatic send(input logic [7:0] b, input logic echo);
        in_valid = 1'b1;
        in_byte  = b;
        if (echo) exp_q.push_back(b);
        tick();
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    // Wait for the gate to settle back to idle ECHO with nothing pending.
    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (exp_q.size() == 0 && !out_valid && !unlocked && !locked) ok = 1'b1;
            else tick();
        end
        check(name, ok, 1'b1);
    endtask

    // Wait until the DUT presents a given message byte.
    task automatic wait_msg(input logic [7:0] b, output logic found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (out_valid && unlocked && out_byte == b) found = 1'b1;
            else tick();
        end
    endtask

    // Monitor: every transfer is compared against the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL out_unexpected: got %02h expected none", out_byte);
                end else begin
                    r_exp = exp_q.pop_front();
                    if (out_byte !== r_exp) begin
                        n_errors++;
                        $display("FAIL out_byte: got %02h expected %02h", out_byte, r_exp);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte",  out_byte,  0);
        check("rst_unlocked",  unlocked,  0);
        check("rst_locked",    locked,    0);
        check("rst_overflow",  overflow,  0);
        rst = 1'b0;
        tick();

        // "aaab": prefix reuse after the third 'a'
        send(c_A, 1); send(c_A, 1); send(c_A, 1);
        check("t1_no_early_unlock", unlocked, 0);
        send(c_B, 1);
        check("t1_unlocked", unlocked, 1);
        exp_q.push_back(c_O); exp_q.push_back(c_K);
        wait_idle("t1_done");

        // Backpressure during SEND holds 'O'
        send(c_A, 1); send(c_A, 1); send(c_B, 1);
        exp_q.push_back(c_O); exp_q.push_back(c_K);
        wait_msg(c_O, r_found);
        check("t2_reach_send", r_found, 1);
        out_ready = 1'b0;
        repeat (5) begin
            tick();
            check("t2_hold", {out_valid, out_byte}, {1'b1, c_O});
        end
        out_ready = 1'b1;
        wait_idle("t2_done");

        // Overflow: third byte dropped while sink stalls
        out_ready = 1'b0;
        send(8'h11, 1); send(8'h22, 1);
        check("t3_no_ovf_yet", overflow, 0);
        send(8'h33, 0);
        check("t3_ovf", overflow, 1);
        out_ready = 1'b1;
        wait_idle("t3_done");
        check("t3_sticky", overflow, 1);

        // Reset in SEND after byte 0
        send(c_A, 1); send(c_A, 1); send(c_B, 1);
        exp_q.push_back(c_O);
        wait_msg(c_K, r_found);
        check("t4_reach_k", r_found, 1);
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        check("t4_out_valid", out_valid, 0);
        check("t4_out_byte",  out_byte,  0);
        check("t4_unlocked",  unlocked,  0);
        check("t4_overflow",  overflow,  0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_queue", exp_q.size(), 0);

        // Input during DRAIN/SEND is discarded and does not advance m
        send(c_A, 1); send(c_A, 1); send(c_B, 1);
        exp_q.push_back(c_O); exp_q.push_back(c_K);
        send(c_A, 0); send(c_A, 0);
        wait_idle("t5_done");
        check("t5_overflow", overflow, 0);
        send(c_B, 1);
        check("t5_m_cleared", unlocked, 0);
        wait_idle("t5_idle");

        // Lockout after two failures
        rst = 1'b1; tick(); rst = 1'b0; tick();
        send(c_A, 1); send(c_X, 1);
        check("t6_one_fail", locked, 0);
        send(c_A, 1); send(c_X, 1);
        check("t6_locked", locked, 1);
        send(c_A, 1); send(c_A, 1); send(c_B, 1);
        check("t6_no_unlock", unlocked, 0);
        check("t6_still_locked", locked, 1);
        n_locked = 4;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (locked) n_locked++;
            else break;
        end
        check("t6_lock_cycles", n_locked, 8);
        wait_idle("t6_idle");
        send(c_A, 1); send(c_A, 1); send(c_B, 1);
        check("t6_unlock_after", unlocked, 1);
        exp_q.push_back(c_O); exp_q.push_back(c_K);
        wait_idle("t6_done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keyed_echo_gate.md
# keyed_echo_gate

Parametrised byte-stream echo gate, placed between the UART receiver and transmitter. Every received byte is echoed back through a small buffer while a prefix-aware (KMP) matcher searches the stream for a key. When the key is found, the gate stops echoing and sends a fixed message. A configurable lockout throttles repeated failed attempts.

## Interface
- `KEY_LEN`, default 20: key length in bytes, ≥1.
- `KEY`, default 0: `[8*KEY_LEN-1:0]`; byte i = `KEY[8i+7:8i]`, matched first-to-last from byte 0.
- `MSG_LEN`, default 40: message length in bytes, ≥1.
- `MSG`, default 0: `[8*MSG_LEN-1:0]`; byte 0 is sent first.
- `MAX_FAILS`, default 0: failures allowed before lockout; 0 disables lockout.
- `LOCKOUT_CYCLES`, default 1024: lockout duration in clocks, ≥1.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe; `in_byte` is valid this cycle. No backpressure is possible.
- `in_byte`  in  8  received byte.
- `out_valid`  out  1  `out_byte` is valid.
- `out_ready`  in  1  sink accepts the byte; a transfer occurs when `out_valid && out_ready`.
- `out_byte`  out  8  byte to transmit.
- `unlocked`  out  1  high while in DRAIN or SEND.
- `locked`  out  1  high while in LOCKED.
- `overflow`  out  1  sticky; set when an echo byte is dropped.

## Operation
- States: ECHO, LOCKED, DRAIN, SEND.
- **ECHO**
  - Each `in_valid` byte is pushed into a 2-entry echo FIFO.
  - The FIFO head drives `out_byte`; `out_valid` is high while the FIFO is not empty.
  - The same byte advances the matcher: match index `m` (0..KEY_LEN-1) moves along the KMP failure links.
  - A mismatch that leaves `m` lower than `m+1` with prior `m>0` counts as one failure.
- **Key complete:** `m` would reach KEY_LEN.
  - The key's last byte is still echoed.
  - Go to DRAIN; clear the fail counter; set `m=0`.
- **Lockout:** when the fail counter reaches MAX_FAILS (MAX_FAILS>0), go to LOCKED.
- **LOCKED**
  - Echo continues; the matcher is frozen at `m=0`.
  - After LOCKOUT_CYCLES cycles, return to ECHO and clear the fail counter.
- **DRAIN**
  - Input bytes are discarded (not echoed, not matched, and `overflow` is not set).
  - Once the FIFO is empty, go to SEND with message index 0.
- **SEND**
  - `out_valid=1`, `out_byte=MSG[idx]`; `idx` advances on each transfer.
  - The transfer of byte MSG_LEN-1 returns the gate to ECHO on the next cycle.
  - Input is discarded.
- **FIFO full with `in_valid`:**
  - If a pop happens in the same cycle, the push succeeds and the count is unchanged.
  - Otherwise the byte is dropped and `overflow` is set. The matcher still sees the dropped byte.
- **Reset (any state, mid-message included):**
  - State = ECHO; FIFO empty; `m`, message index, fail counter, lockout timer all 0.
  - All outputs are 0, so `out_byte=0`.

## Timing
- `in_valid` at cycle t gives `out_valid=1` at t+1 when the FIFO was empty; the FIFO is registered and has no bypass.
- Matcher state and fail counter update at t+1.
- Key byte completes at t: `unlocked=1` at t+1.
- FIFO becomes empty at cycle d: SEND and `out_valid` with MSG byte 0 at d+1.
- `out_byte` stays stable while `out_valid && !out_ready`.
- Lockout entered at t+1: `locked` is high for exactly LOCKOUT_CYCLES cycles.
- Maximum sustained rate is one byte per cycle in and one per cycle out.

## Structure
- Package `keyed_echo_pkg` holds:
  - the `gate_state_t` enum;
  - the elaboration-time function `kmp_fail(KEY, KEY_LEN)`, which returns the failure table as a localparam array.
- Sub-module `byte_fifo` (parameter DEPTH, default 2): push, pop, full, empty, head.
- Matcher, lockout timer and message sequencer stay in the top module.

## Test plan
- `KEY="aab"`, `MSG="OK"`. Send "aaab" with `out_ready=1`.
  - Echo is "aaab".
  - `unlocked` rises the cycle after the 'b'.
  - Then 'O','K' are sent; the gate returns to ECHO.
  - This checks KMP prefix reuse.
- `out_ready=0` during SEND for 5 cycles: `out_byte` holds 'O'; no byte is skipped or repeated.
- `MAX_FAILS=2`, `LOCKOUT_CYCLES=8`. Send "ax", "ax".
  - `locked` is high for 8 cycles.
  - Sending "aab" while locked does not unlock, but is echoed.
  - Sending "aab" after lockout does unlock.
- `out_ready=0`, three consecutive `in_valid` bytes 0x11, 0x22, 0x33:
  - `overflow=1`.
  - Echo is 0x11, 0x22 only.
- Assert `rst` during SEND after byte 0: the next cycle has ECHO, `out_valid=0`, `unlocked=0`, `overflow=0`.
- Bytes arriving during DRAIN/SEND: none are echoed, `m=0` afterwards, `overflow` stays 0.
